// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC frame scheduler and the encode engine it drives.
package lpc_pkg;

   localparam int LPC_ORDER = 10;
   localparam int FRAME_LEN = 160;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_KICK,
      ST_RUN,
      ST_PRIME,
      ST_SEND,
      ST_FLUSH,
      ST_ERR
   } lpc_state_e;

endpackage

// File: rtl/lpc_readout_seq.sv
// Readout index sequencer: walks the ORDER coefficients then the residuals,
// one item per PRIME/SEND pair, and maps each index onto a memory select and address.
module lpc_readout_seq
   import lpc_pkg::*;
#(
   parameter int N_SAMPLES = FRAME_LEN,
   parameter int ORDER     = LPC_ORDER,
   parameter int IDX_W     = $clog2(ORDER + N_SAMPLES),
   parameter int ADDR_W    = $clog2(N_SAMPLES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic              send_i,
   input  logic              out_ready_i,
   output logic              rd_sel_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              out_valid_o,
   output logic              out_last_o,
   output logic              xfer_o
);

   localparam int TOTAL = ORDER + N_SAMPLES;

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             last;

   assign last        = (idx_q == IDX_W'(TOTAL - 1));
   assign out_valid_o = send_i;
   assign out_last_o  = send_i & last;
   assign xfer_o      = send_i & out_ready_i;

   // The index only moves on an accepted item, so the address stays put through a stall.
   always_comb begin
      idx_d = idx_q;
      if (start_i) begin
         idx_d = '0;
      end else if (xfer_o && !last) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   always_comb begin
      rd_sel_o  = 1'b0;
      rd_addr_o = ADDR_W'(idx_q);
      if (idx_q >= IDX_W'(ORDER)) begin
         rd_sel_o  = 1'b1;
         rd_addr_o = ADDR_W'(idx_q - IDX_W'(ORDER));
      end
   end

endmodule

// File: rtl/lpc_frame_scheduler.sv
// Frame sequencer around the LPC encoder: load samples, kick and watch the encoder,
// stream coefficients and residuals out, then reset the encoder for the next frame.
module lpc_frame_scheduler
   import lpc_pkg::*;
#(
   parameter int N_SAMPLES      = FRAME_LEN,
   parameter int ORDER          = LPC_ORDER,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int IDX_W         = $clog2(ORDER + N_SAMPLES),
   localparam int ADDR_W        = $clog2(N_SAMPLES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic              enc_start,
   input  logic              enc_done,
   output logic              enc_reset,
   output logic              rd_sel,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              err,
   input  logic              clear_err,
   output logic [15:0]       frame_count,
   output lpc_state_e        state_dbg
);

   // Handshakes: a sample moves when in_valid & in_ready, a readout item when
   // out_valid & out_ready, both on the rising edge; valid never waits on ready.

   lpc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [15:0]       wdog_q, wdog_d;
   logic [15:0]       frame_q, frame_d;
   logic              ro_start;
   logic              ro_xfer;

   lpc_readout_seq #(
      .N_SAMPLES (N_SAMPLES),
      .ORDER     (ORDER),
      .IDX_W     (IDX_W),
      .ADDR_W    (ADDR_W)
   ) u_readout (
      .clk         (clk),
      .reset       (reset),
      .start_i     (ro_start),
      .send_i      (state_q == ST_SEND),
      .out_ready_i (out_ready),
      .rd_sel_o    (rd_sel),
      .rd_addr_o   (rd_addr),
      .out_valid_o (out_valid),
      .out_last_o  (out_last),
      .xfer_o      (ro_xfer)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wdog_d    = wdog_q;
      frame_d   = frame_q;
      in_ready  = 1'b0;
      enc_start = 1'b0;
      ro_start  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (cnt_q == ADDR_W'(N_SAMPLES - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_KICK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_KICK: begin
            enc_start = 1'b1;
            wdog_d    = '0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            wdog_d = wdog_q + 16'd1;
            // A completion landing on the terminal count still counts as success.
            if (enc_done) begin
               ro_start = 1'b1;
               state_d  = ST_PRIME;
            end else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_ERR;
            end
         end
         ST_PRIME: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (ro_xfer) state_d = out_last ? ST_FLUSH : ST_PRIME;
         end
         ST_FLUSH: begin
            frame_d = frame_q + 16'd1;
            cnt_d   = '0;
            state_d = enable ? ST_LOAD : ST_IDLE;
         end
         ST_ERR: begin
            if (clear_err) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wdog_q  <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wdog_q  <= wdog_d;
         frame_q <= frame_d;
      end
   end

   assign mem_wen     = in_valid & in_ready;
   assign mem_waddr   = cnt_q;
   assign busy        = (state_q != ST_IDLE);
   assign err         = (state_q == ST_ERR);
   assign enc_reset   = reset | (state_q == ST_FLUSH) | (state_q == ST_ERR);
   assign frame_count = frame_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_lpc_frame_scheduler.sv
// Directed bench for lpc_frame_scheduler: host-side drivers, an encoder responder,
// and a scoreboard of expected write addresses and readout items.
module tb_lpc_frame_scheduler;
   import lpc_pkg::*;

   localparam int N   = 160;
   localparam int ORD = 10;
   localparam int TOT = ORD + N;
   localparam int TMO = 1000;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        in_valid;
   logic        in_ready;
   logic        mem_wen;
   logic [7:0]  mem_waddr;
   logic        enc_start;
   logic        enc_done;
   logic        enc_reset;
   logic        rd_sel;
   logic [7:0]  rd_addr;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        err;
   logic        clear_err;
   logic [15:0] frame_count;
   lpc_state_e  state_dbg;

   lpc_frame_scheduler #(
      .N_SAMPLES      (N),
      .ORDER          (ORD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mem_wen     (mem_wen),
      .mem_waddr   (mem_waddr),
      .enc_start   (enc_start),
      .enc_done    (enc_done),
      .enc_reset   (enc_reset),
      .rd_sel      (rd_sel),
      .rd_addr     (rd_addr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .err         (err),
      .clear_err   (clear_err),
      .frame_count (frame_count),
      .state_dbg   (state_dbg)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_wq[$];
   logic [9:0] exp_q[$];
   logic [9:0] cap     [TOT];
   logic [9:0] ref_cap [TOT];
   int         frame_items = 0;
   int         done_delay  = -1;
   int         enc_cnt     = -1;

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running at 1 ms");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Item word = {out_last, rd_sel, rd_addr}; coefficients first, then residuals.
   function automatic logic [9:0] item_of(input int i);
      logic last;
      last = (i == TOT - 1);
      if (i < ORD) return {last, 1'b0, 8'(i)};
      return {last, 1'b1, 8'(i - ORD)};
   endfunction

   // ---------------- encoder responder ----------------
   initial begin
      enc_done = 1'b0;
      forever begin
         @(negedge clk);
         if (enc_reset) begin
            enc_cnt  = -1;
            enc_done = 1'b0;
         end else if (enc_start) begin
            enc_cnt = done_delay;
         end else if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_cnt == 0) begin
               enc_done = 1'b1;
               enc_cnt  = -1;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin
      logic       prev_stall;
      logic       prev_start;
      logic [8:0] prev_rd;
      logic [9:0] item;
      prev_stall = 1'b0;
      prev_start = 1'b0;
      prev_rd    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
            prev_start = 1'b0;
         end else begin
            check("wen_rule", 32'(mem_wen), 32'(in_valid & in_ready));
            if (mem_wen) begin
               if (exp_wq.size() == 0) check("unexpected_write", 32'(mem_waddr), 32'hFFFF);
               else check("waddr", 32'(mem_waddr), 32'(exp_wq.pop_front()));
            end
            if (out_valid && out_ready) begin
               item = {out_last, rd_sel, rd_addr};
               if (exp_q.size() == 0) check("unexpected_item", 32'(item), 32'hFFFF);
               else check("item", 32'(item), 32'(exp_q.pop_front()));
               if (frame_items < TOT) cap[frame_items] = item;
               frame_items++;
            end
            if (out_valid && prev_stall) check("addr_hold", 32'({rd_sel, rd_addr}), 32'(prev_rd));
            if (enc_start) check("start_width", 32'(prev_start), 32'd0);
            prev_stall = out_valid & ~out_ready;
            prev_rd    = {rd_sel, rd_addr};
            prev_start = enc_start;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_frame(input int stall_pct, input int drop_at);
      int n;
      int guard;
      n     = 0;
      guard = 0;
      frame_items = 0;
      for (int i = 0; i < N; i++) exp_wq.push_back(8'(i));
      for (int i = 0; i < TOT; i++) exp_q.push_back(item_of(i));
      while (n < N && guard < 5000) begin
         @(posedge clk); #1;
         if (n == drop_at) enable = 1'b0;
         in_valid = ($urandom_range(0, 99) >= stall_pct);
         @(negedge clk); #1;
         if (in_valid && in_ready) n++;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("load_count", 32'(n), 32'(N));
      check("load_wq_empty", 32'(exp_wq.size()), 32'd0);
      @(negedge clk); #1;
      check("enc_start_after_load", 32'(enc_start), 32'd1);
   endtask

   task automatic drain(input int ready_pct, input int stop_after);
      int guard;
      guard = 0;
      while (frame_items < stop_after && guard < 6000) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk); #1;
         guard++;
      end
      check("drain_items", 32'(frame_items), 32'(stop_after));
   endtask

   task automatic finish_frame(input int fc, input logic cont);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk); #1;
      check("flush_enc_reset", 32'(enc_reset), 32'd1);
      check("flush_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
      check("frame_count", 32'(frame_count), 32'(fc));
      check("post_enc_reset", 32'(enc_reset), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'(cont));
      check("post_busy", 32'(busy), 32'(cont));
      check("readout_q_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_to_err();
      int n;
      n = 0;
      load_frame(0, -1);
      while (!err && n < 1200) begin
         @(negedge clk); #1;
         n++;
      end
      check("wdog_cycles", 32'(n), 32'(TMO + 1));
      check("err_set", 32'(err), 32'd1);
      check("err_enc_reset", 32'(enc_reset), 32'd1);
      check("err_in_ready", 32'(in_ready), 32'd0);
      check("err_out_valid", 32'(out_valid), 32'd0);
      repeat (3) begin @(negedge clk); #1; end
      check("err_sticky", 32'(err), 32'd1);
      check("err_enc_reset_held", 32'(enc_reset), 32'd1);
      check("err_no_readout", 32'(exp_q.size()), 32'(TOT));
      check("err_frame_count", 32'(frame_count), 32'd2);
      exp_q.delete();
      @(posedge clk); #1;
      enable    = 1'b0;
      clear_err = 1'b1;
      @(posedge clk); #1;
      clear_err = 1'b0;
      @(negedge clk); #1;
      check("clear_err", 32'(err), 32'd0);
      check("clear_idle", 32'(state_dbg), 32'(ST_IDLE));
      check("clear_enc_reset", 32'(enc_reset), 32'd0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clear_err = 1'b0;

      // Reset state
      repeat (3) begin @(negedge clk); #1; end
      check("rst_enc_reset", 32'(enc_reset), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) begin @(negedge clk); #1; end
      check("idle_hold", 32'(state_dbg), 32'(ST_IDLE));
      check("idle_enc_reset", 32'(enc_reset), 32'd0);

      // Single frame, full throughput
      enable     = 1'b1;
      done_delay = 500;
      load_frame(0, -1);
      drain(100, TOT);
      finish_frame(1, 1'b1);
      check("pin_item0",   32'(cap[0]),   32'h000);
      check("pin_item9",   32'(cap[9]),   32'h009);
      check("pin_item10",  32'(cap[10]),  32'h100);
      check("pin_item168", 32'(cap[168]), 32'h19E);
      check("pin_item169", 32'(cap[169]), 32'h39F);
      for (int i = 0; i < TOT; i++) ref_cap[i] = cap[i];

      // Backpressure with host stalls on the load side
      done_delay = 40;
      load_frame(50, -1);
      drain(30, TOT);
      finish_frame(2, 1'b1);
      for (int i = 0; i < TOT; i++) check("bp_sequence", 32'(cap[i]), 32'(ref_cap[i]));

      // Watchdog expiry, then done on the terminal-count cycle
      done_delay = -1;
      run_to_err();
      enable     = 1'b1;
      done_delay = TMO;
      load_frame(0, -1);
      drain(100, TOT);
      finish_frame(3, 1'b1);
      check("tc_tie_no_err", 32'(err), 32'd0);

      // enable dropped mid-load
      done_delay = 30;
      load_frame(0, 80);
      drain(100, TOT);
      finish_frame(4, 1'b0);
      repeat (4) begin @(negedge clk); #1; end
      check("drop_stays_idle", 32'(busy), 32'd0);
      check("drop_frame_count", 32'(frame_count), 32'd4);

      // Reset in the middle of readout
      enable     = 1'b1;
      done_delay = 20;
      load_frame(0, -1);
      drain(100, 50);
      @(posedge clk); #1;
      reset     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk); #1;
      check("midrst_enc_reset_comb", 32'(enc_reset), 32'd1);
      @(negedge clk); #1;
      check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_enc_reset", 32'(enc_reset), 32'd1);
      check("midrst_frame_count", 32'(frame_count), 32'd0);
      check("midrst_items", 32'(frame_items), 32'd50);
      @(posedge clk); #1;
      enable = 1'b0;
      reset  = 1'b0;
      exp_q.delete();
      repeat (3) begin @(negedge clk); #1; end
      check("post_rst_idle", 32'(busy), 32'd0);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
